// File: rtl/t_ff_if.sv
`default_nettype none
// ============================================================================
//  Module      : t_ff_if
//  Description : Toggle-enable / state bundle between a T flip-flop register
//                and its user.
//  Revision    : 1.0
// ============================================================================
interface t_ff_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q;

    // The user drives the toggle enables and observes the state.
    modport master (
        output t,
        input  q
    );

    modport slave (
        input  t,
        output q
    );
endinterface
`default_nettype wire

// File: rtl/t_ff.sv
`default_nettype none
// ============================================================================
//  Module      : t_ff
//  Description : Vectorised T flip-flop register; each bit inverts on a rising
//                clk edge when its toggle enable is high, with async reset.
//  Revision    : 1.0
// ============================================================================
module t_ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire     clk,
    input  wire     rst,
    t_ff_if.slave   bus
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q ^ bus.t;
    end

    // Reset takes priority over any toggle, including on a coincident edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.q = q_q;

endmodule
`default_nettype wire

// File: tb/tb_t_ff.sv
`default_nettype none
// ============================================================================
//  Module      : tb_t_ff
//  Description : Self-checking bench for t_ff, single-bit and 4-bit builds.
//  Revision    : 1.0
// ============================================================================
module tb_t_ff;

    localparam logic [3:0] C_RST_B = 4'b0011;

    logic clk;
    logic rst_a;
    logic rst_b;

    t_ff_if #(.WIDTH(1)) ifa ();
    t_ff_if #(.WIDTH(4)) ifb ();

    t_ff #(.WIDTH(1), .RST_VAL(1'b0)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    t_ff #(.WIDTH(4), .RST_VAL(C_RST_B)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic [3:0] t;
        logic [3:0] exp_q;
    } vec_t;

    int total;
    int bad;
    logic q_model;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Drive on the falling edge, observe just after the following rising edge.
    task automatic step_a(input logic r, input logic t);
        @(negedge clk);
        rst_a   = r;
        ifa.t   = t;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic r, input logic [3:0] t);
        @(negedge clk);
        rst_b   = r;
        ifb.t   = t;
        @(posedge clk);
        #1;
    endtask

    vec_t va [14];
    vec_t vb [8];

    initial begin
        total = 0;
        bad   = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.t = 1'b0;
        ifb.t = 4'b0000;
        $monitor("%0t rst=%b t=%b q=%b", $time, rst_a, ifa.t, ifa.q);

        // Single bit: reset, priority, toggle run, hold, single pulse.
        va[0]  = '{1'b1, 4'b0000, 4'b0000};
        va[1]  = '{1'b1, 4'b0001, 4'b0000};
        va[2]  = '{1'b0, 4'b0001, 4'b0001};
        va[3]  = '{1'b0, 4'b0001, 4'b0000};
        va[4]  = '{1'b0, 4'b0001, 4'b0001};
        va[5]  = '{1'b0, 4'b0001, 4'b0000};
        va[6]  = '{1'b0, 4'b0001, 4'b0001};
        va[7]  = '{1'b0, 4'b0000, 4'b0001};
        va[8]  = '{1'b0, 4'b0000, 4'b0001};
        va[9]  = '{1'b0, 4'b0000, 4'b0001};
        va[10] = '{1'b0, 4'b0000, 4'b0001};
        va[11] = '{1'b0, 4'b0000, 4'b0001};
        va[12] = '{1'b0, 4'b0001, 4'b0000};
        va[13] = '{1'b0, 4'b0000, 4'b0000};

        // Four bits with RST_VAL=0011: independent per-bit toggles.
        vb[0] = '{1'b1, 4'b0000, 4'b0011};
        vb[1] = '{1'b0, 4'b1010, 4'b1001};
        vb[2] = '{1'b0, 4'b1010, 4'b0011};
        vb[3] = '{1'b0, 4'b0101, 4'b0110};
        vb[4] = '{1'b0, 4'b1111, 4'b1001};
        vb[5] = '{1'b0, 4'b0000, 4'b1001};
        vb[6] = '{1'b1, 4'b1111, 4'b0011};
        vb[7] = '{1'b0, 4'b0001, 4'b0010};

        for (int i = 0; i < 14; i++) begin
            step_a(va[i].rst, va[i].t[0]);
            check($sformatf("vecA[%0d]", i), {3'b000, ifa.q}, va[i].exp_q);
        end

        for (int i = 0; i < 8; i++) begin
            step_b(vb[i].rst, vb[i].t);
            check($sformatf("vecB[%0d]", i), ifb.q, vb[i].exp_q);
        end

        // Async reset assert mid-cycle, then held with t=1.
        step_a(1'b0, 1'b1);
        check("async_pre", {3'b000, ifa.q}, 4'b0001);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("async_assert", {3'b000, ifa.q}, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, 1'b1);
            check($sformatf("rst_hold[%0d]", i), {3'b000, ifa.q}, 4'b0000);
        end

        // Release alone must not change q before an edge.
        @(negedge clk);
        rst_a = 1'b0;
        ifa.t = 1'b0;
        #1;
        check("release_no_edge", {3'b000, ifa.q}, 4'b0000);

        // Mid-stream reset between edges 3 and 4, then resume from RST_VAL.
        q_model = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            if (e == 4) begin
                step_a(1'b1, 1'b1);
                q_model = 1'b0;
            end else begin
                step_a(1'b0, 1'b1);
                q_model = q_model ^ 1'b1;
            end
            check($sformatf("stream_edge%0d", e), {3'b000, ifa.q}, {3'b000, q_model});
            if (e == 3) begin
                @(negedge clk);
                rst_a = 1'b1;
                #1;
                check("stream_async", {3'b000, ifa.q}, 4'b0000);
            end
        end

        // Async reset on the vector build.
        step_b(1'b0, 4'b1100);
        check("vecB_pre", ifb.q, 4'b1110);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("vecB_async", ifb.q, C_RST_B);

        $monitoroff;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
